// File: rtl/memory_pkg.sv
// Shared constants and FSM state type for the memory gather (read side) and write-side mux.
package memory_pkg;

  localparam int MEM_NUM_DEF          = 6;
  localparam int OUTPUT_MEM_DEPTH_DEF = 6;
  localparam int DATA_WIDTH_DEF       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/memory_gather_if.sv
// Output word stream. A word moves on every rising edge where out_v and out_rdy are both high;
// once out_v is raised the master holds out_d/out_bank/out_last steady until that transfer.
interface memory_gather_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BANK_W     = 3
);
    logic                  out_v;
    logic                  out_rdy;
    logic [DATA_WIDTH-1:0] out_d;
    logic [BANK_W-1:0]     out_bank;
    logic                  out_last;

    modport master (output out_v, output out_d, output out_bank, output out_last, input out_rdy);
    modport slave  (input out_v, input out_d, input out_bank, input out_last, output out_rdy);
endinterface

// File: rtl/gather_skid_fifo.sv
// Two-entry FIFO holding returned read words; head entry is presented combinationally on rd_data.
module gather_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/memory_gather.sv
// Drains every bank of a banked RAM, bank-major, into a single backpressured word stream.
module memory_gather
    import memory_pkg::*;
#(
    parameter int MEM_NUM          = MEM_NUM_DEF,
    parameter int OUTPUT_MEM_DEPTH = OUTPUT_MEM_DEPTH_DEF,
    parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH       = $clog2(OUTPUT_MEM_DEPTH)
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [MEM_NUM-1:0]            mem_re_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    input  logic [MEM_NUM*DATA_WIDTH-1:0] mem_id,
    memory_gather_if.master               out_if,
    output state_t                        state_o
);
    localparam int BANK_W = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
    localparam int FW     = 1 + BANK_W + DATA_WIDTH;

    state_t              state, state_nxt;
    logic [MEM_NUM-1:0]  bank_oh;
    logic [BANK_W-1:0]   bank_idx;
    logic [ADDR_WIDTH-1:0] addr;
    logic                inflight, inflight_last;
    logic [BANK_W-1:0]   inflight_bank;
    logic [1:0]          fifo_count;
    logic [FW-1:0]       fifo_rd, fifo_wr;
    logic                start_ok, issue, pop, addr_wrap, last_bank, last_rd, done_evt;
    logic [2:0]          occupancy;

    assign pop       = out_if.out_v & out_if.out_rdy;
    assign start_ok  = (state == IDLE) & start_i & ~done_o;
    assign addr_wrap = (addr == ADDR_WIDTH'(OUTPUT_MEM_DEPTH - 1));
    assign last_bank = (bank_idx == BANK_W'(MEM_NUM - 1));
    assign last_rd   = addr_wrap & last_bank;
    // Words already owed to the stream (queued plus the one on its way back from RAM).
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    assign issue     = (state == READ) & (occupancy < (3'd2 + {2'b00, pop}));
    assign done_evt  = (state == DRAIN) & pop & out_if.out_last;

    assign mem_re_o   = issue ? bank_oh : '0;
    assign mem_addr_o = addr;
    assign busy_o     = (state != IDLE);
    assign state_o    = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = READ;
            READ:    if (issue && last_rd) state_nxt = DRAIN;
            DRAIN:   if (pop && out_if.out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr          <= '0;
            bank_oh       <= MEM_NUM'(1);
            bank_idx      <= '0;
            inflight      <= 1'b0;
            inflight_bank <= '0;
            inflight_last <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_bank <= bank_idx;
            inflight_last <= last_rd;
            done_o        <= done_evt;
            if (start_ok) begin
                addr     <= '0;
                bank_oh  <= MEM_NUM'(1);
                bank_idx <= '0;
            end else if (issue) begin
                if (addr_wrap) begin
                    addr <= '0;
                    // The pointer parks on the final bank; only a new start rewinds it.
                    if (!last_bank) begin
                        bank_oh  <= bank_oh << 1;
                        bank_idx <= bank_idx + BANK_W'(1);
                    end
                end else begin
                    addr <= addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign fifo_wr = {inflight_last, inflight_bank,
                      mem_id[int'(inflight_bank)*DATA_WIDTH +: DATA_WIDTH]};

    gather_skid_fifo #(.WIDTH(FW)) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (inflight),
        .push_data (fifo_wr),
        .pop       (pop),
        .rd_data   (fifo_rd),
        .count     (fifo_count)
    );

    assign out_if.out_v = (fifo_count != 2'd0);
    assign {out_if.out_last, out_if.out_bank, out_if.out_d} = fifo_rd;
endmodule

// File: tb/tb_memory_gather.sv
// Bench for memory_gather: RAM model returning {bank,addr} words, a queue-based stream model and directed scenarios.
module tb_memory_gather;
  import memory_pkg::*;

  localparam int MEM_NUM = 6;
  localparam int DEPTH   = 6;
  localparam int DW      = 8;
  localparam int AW      = 3;
  localparam int BW      = 3;
  localparam int TOTAL   = MEM_NUM * DEPTH;
  localparam int W       = 1 + BW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start_i = 1'b0;
  logic busy_o, done_o;
  logic [MEM_NUM-1:0] mem_re_o;
  logic [AW-1:0] mem_addr_o;
  logic [MEM_NUM*DW-1:0] mem_id = '0;
  state_t state_o;
  int cyc = 0;
  int rdy_mode = 0;

  memory_gather_if #(.DATA_WIDTH(DW), .BANK_W(BW)) out_if ();

  memory_gather #(
    .MEM_NUM(MEM_NUM), .OUTPUT_MEM_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o), .mem_id(mem_id),
    .out_if(out_if), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM: bank k at address a holds {k, a}; idle banks show a filler value.
  always @(posedge clk) begin
    for (int k = 0; k < MEM_NUM; k++)
      mem_id[k*DW +: DW] <= mem_re_o[k] ? {4'(k), 4'(mem_addr_o)} : 8'hEE;
  end

  // Sink ready: mode 0 always ready, mode 1 repeats 1,0,0,1.
  initial begin
    out_if.out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_if.out_rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_word, exp_word, prev_word;
  logic m_busy = 1'b0, m_done = 1'b0, prev_stall = 1'b0, hs, acc;
  int m_rd_idx = 0, m_out = 0;
  int run_words = 0, run_dones = 0, first_cyc = -1, last_cyc = -1, done_cyc = -1;
  logic [W-1:0] first_word = '0, last_word = '0;

  always @(negedge clk) begin
    cur_word = {out_if.out_last, out_if.out_bank, out_if.out_d};
    if (!nrst) begin
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_re", mem_re_o, 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_out", {out_if.out_v, cur_word}, 0);
      exp_q.delete();
      m_busy = 0; m_done = 0; prev_stall = 0; m_out = 0; m_rd_idx = 0;
    end else begin
      hs = out_if.out_v && out_if.out_rdy;
      check("busy", busy_o, m_busy);
      check("done", done_o, m_done);
      if (done_o) begin run_dones++; done_cyc = cyc; end
      if (!m_busy) check("re_quiet", mem_re_o, 0);
      if (mem_re_o != 0) begin
        check("rd_credit", ((m_out - int'(hs)) < 2), 1);
        check("rd_bank", mem_re_o, (m_rd_idx < TOTAL) ? (64'd1 << (m_rd_idx / DEPTH)) : 64'd0);
        check("rd_addr", mem_addr_o, m_rd_idx % DEPTH);
        m_rd_idx++;
        m_out++;
      end
      if (prev_stall) check("stall_hold", {out_if.out_v, cur_word}, {1'b1, prev_word});
      if (hs) begin
        if (exp_q.size() == 0) check("unexpected_word", cur_word, '1);
        else begin
          exp_word = exp_q.pop_front();
          check("word", cur_word, exp_word);
        end
        m_out--;
        if (run_words == 0) begin first_cyc = cyc; first_word = cur_word; end
        run_words++;
        last_cyc = cyc;
        last_word = cur_word;
      end
      prev_stall = out_if.out_v && !out_if.out_rdy;
      prev_word = cur_word;
      // Model update for the next cycle.
      acc = start_i && !m_busy && !m_done;
      m_done = hs && out_if.out_last;
      if (hs && out_if.out_last) m_busy = 0;
      if (acc) begin
        m_busy = 1;
        m_rd_idx = 0;
        run_words = 0; run_dones = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        for (int b = 0; b < MEM_NUM; b++)
          for (int a = 0; a < DEPTH; a++)
            exp_q.push_back({(b == MEM_NUM-1 && a == DEPTH-1), 3'(b), 4'(b), 4'(a)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done_o && i < budget) begin step(); i++; end
    check("done_seen", done_o, 1);
  endtask

  task automatic wait_words(input int n, input int budget);
    int i = 0;
    while (run_words < n && i < budget) begin step(); i++; end
    check("words_reached", run_words >= n, 1);
  endtask

  // ---------------- directed scenarios ----------------
  int d_cyc;

  initial begin
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    // Full drain, always ready, start sampled at edge 10.
    wait_cyc(9);
    pulse_start();
    wait_done(200);
    step();
    check("t1_first_cyc", first_cyc, 12);
    check("t1_last_cyc", last_cyc, 47);
    check("t1_done_cyc", done_cyc, 48);
    check("t1_words", run_words, 36);
    check("t1_first_word", first_word, 12'h000);
    check("t1_last_word", last_word, 12'hD55);

    // Backpressure 1,0,0,1.
    rdy_mode = 1;
    pulse_start();
    wait_done(600);
    step();
    check("t2_words", run_words, 36);
    check("t2_dones", run_dones, 1);
    rdy_mode = 0;

    // Second start while busy is ignored.
    pulse_start();
    wait_words(10, 200);
    pulse_start();
    wait_done(200);
    step();
    check("t3_words", run_words, 36);
    check("t3_dones", run_dones, 1);

    // Reset during word 20, then a clean restart.
    pulse_start();
    wait_words(20, 200);
    #2 nrst = 1'b0;
    #1;
    check("t4_async_busy", busy_o, 0);
    check("t4_async_out_v", out_if.out_v, 0);
    check("t4_async_re", mem_re_o, 0);
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    step();
    pulse_start();
    wait_done(200);
    step();
    check("t4_words", run_words, 36);
    check("t4_first_word", first_word, 12'h000);
    check("t4_dones", run_dones, 1);

    // Back-to-back: start in the done cycle is ignored, one cycle later is accepted.
    pulse_start();
    wait_done(200);
    d_cyc = cyc;
    start_i = 1'b1;
    step();
    step();
    start_i = 1'b0;
    wait_done(200);
    step();
    check("t5_first_cyc", first_cyc, d_cyc + 4);
    check("t5_words", run_words, 36);
    check("t5_dones", run_dones, 1);

    repeat (3) step();
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
